param_alu: RTL and testbench

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_addsub.sv | 16 +
 rtl/param_alu.sv | 173 +++++++++++++++++
 tb/tb_param_alu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the parametrised ALU.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD_Y = 2'b01,
        EXEC   = 2'b10,
        DONE   = 2'b11
    } state_t;

endpackage

// File: rtl/alu_addsub.sv
// N-bit adder/subtractor; sub inverts b and supplies the carry-in.
module alu_addsub #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    // Two's-complement add of a and (optionally inverted) b plus carry-in.
    always_comb begin
        sum = a + (b ^ {N{sub}}) + N'(sub);
    end

endmodule

// File: rtl/param_alu.sv
// Multi-cycle ALU: add/sub, Booth radix-2 signed multiply, non-restoring
// unsigned divide, all sharing a single (W+1)-bit adder/subtractor.
module param_alu
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     sel,
    input  logic [2*W-1:0] inbus,
    output logic [2*W-1:0] outbus,
    output logic           finish,
    output logic           busy,
    output logic           ovf,
    output logic           err
);

    localparam int unsigned CW = $clog2(W);

    state_t        state;
    logic [1:0]    sel_r;
    logic [W:0]    a;
    logic [W-1:0]  q;
    logic [W-1:0]  m;
    logic          q_m1;
    logic [CW-1:0] cnt;
    logic          bad_ovf;
    logic          bad_err;

    logic [W:0]    add_a;
    logic [W:0]    add_b;
    logic          add_sub;
    logic [W:0]    sum;
    logic [W:0]    acc;
    logic [W:0]    rem_fix;
    logic          last;

    alu_addsub #(.N(W + 1)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (sum)
    );

    // Steer the shared adder: divide range check in LOAD_Y, op step in EXEC.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            LOAD_Y: begin
                add_a   = a;
                add_b   = {1'b0, inbus[W-1:0]};
                add_sub = 1'b1;
            end
            EXEC: begin
                case (sel_r)
                    OP_MUL: begin
                        add_a   = a;
                        add_b   = {m[W-1], m};
                        add_sub = q[0] & ~q_m1;
                    end
                    OP_DIV: begin
                        add_a   = {a[W-1:0], q[W-1]};
                        add_b   = {1'b0, m};
                        add_sub = ~a[W];
                    end
                    default: begin
                        add_a   = {q[W-1], q};
                        add_b   = {m[W-1], m};
                        add_sub = (sel_r == OP_SUB);
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Booth accumulator select, final remainder fix-up and last-step detect.
    always_comb begin
        acc     = (q[0] ^ q_m1) ? sum : a;
        rem_fix = sum[W] ? (sum + {1'b0, m}) : sum;
        last    = (sel_r == OP_ADD) || (sel_r == OP_SUB) || bad_ovf || bad_err
                  || (cnt == CW'(W - 1));
    end

    // Control FSM with datapath registers and registered outputs.
    // A failing divide takes one EXEC cycle so finish lands after edge 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_r   <= OP_ADD;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            bad_ovf <= 1'b0;
            bad_err <= 1'b0;
            outbus  <= '0;
            finish  <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_r <= sel;
                        a     <= (sel == OP_DIV) ? {1'b0, inbus[2*W-1:W]} : '0;
                        q     <= inbus[W-1:0];
                        q_m1  <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD_Y;
                    end
                end
                LOAD_Y: begin
                    m       <= inbus[W-1:0];
                    cnt     <= '0;
                    bad_err <= (sel_r == OP_DIV) && (inbus[W-1:0] == '0);
                    bad_ovf <= (sel_r == OP_DIV) && (inbus[W-1:0] != '0) && !sum[W];
                    state   <= EXEC;
                end
                EXEC: begin
                    if (sel_r == OP_MUL) begin
                        a    <= {acc[W], acc[W:1]};
                        q    <= {acc[0], q[W-1:1]};
                        q_m1 <= q[0];
                    end else if (sel_r == OP_DIV) begin
                        a <= sum;
                        q <= {q[W-2:0], ~sum[W]};
                    end
                    if (last) begin
                        state  <= DONE;
                        finish <= 1'b1;
                        if (bad_ovf || bad_err) begin
                            outbus <= '1;
                            ovf    <= bad_ovf;
                            err    <= bad_err;
                        end else begin
                            case (sel_r)
                                OP_MUL: begin
                                    outbus <= {acc, q[W-1:1]};
                                    ovf    <= 1'b0;
                                end
                                OP_DIV: begin
                                    outbus <= {rem_fix[W-1:0], q[W-2:0], ~sum[W]};
                                    ovf    <= 1'b0;
                                end
                                default: begin
                                    outbus <= {{W{1'b0}}, sum[W-1:0]};
                                    ovf    <= sum[W] ^ sum[W-1];
                                end
                            endcase
                            err <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Self-checking bench for param_alu (W=8): directed corner cases plus
// random operations checked against an arithmetic reference model.
module tb_param_alu;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     sel;
    logic [2*W-1:0] inbus;
    logic [2*W-1:0] outbus;
    logic           finish;
    logic           busy;
    logic           ovf;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;

    param_alu #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sel    (sel),
        .inbus  (inbus),
        .outbus (outbus),
        .finish (finish),
        .busy   (busy),
        .ovf    (ovf),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic void model(input logic [1:0] s, input longint x, input longint y,
                                  output longint out, output bit o, output bit e,
                                  output int lat);
        longint half;
        longint full;
        longint mask;
        longint mask2;
        longint sx;
        longint sy;
        longint r;
        longint ux;
        longint uy;
        half  = longint'(1) << (W - 1);
        full  = longint'(1) << W;
        mask  = full - 1;
        mask2 = (longint'(1) << (2 * W)) - 1;
        sx = x & mask;
        sy = y & mask;
        if (sx >= half) sx -= full;
        if (sy >= half) sy -= full;
        o   = 1'b0;
        e   = 1'b0;
        lat = 2;
        out = 0;
        case (s)
            OP_ADD, OP_SUB: begin
                r   = (s == OP_ADD) ? sx + sy : sx - sy;
                o   = (r >= half) || (r < -half);
                out = r & mask;
            end
            OP_MUL: begin
                out = (sx * sy) & mask2;
                lat = W + 1;
            end
            default: begin
                ux = x & mask2;
                uy = y & mask;
                if (uy == 0) begin
                    e   = 1'b1;
                    out = mask2;
                end else if ((ux >> W) >= uy) begin
                    o   = 1'b1;
                    out = mask2;
                end else begin
                    out = ((ux % uy) << W) | (ux / uy);
                    lat = W + 1;
                end
            end
        endcase
    endfunction

    // One operation starting at a falling edge; optional stray start mid-run.
    task automatic run_op(input logic [1:0] s, input longint x, input longint y, input bit inj);
        longint e_out;
        bit     e_ovf;
        bit     e_err;
        int     e_lat;
        int     got;
        model(s, x, y, e_out, e_ovf, e_err, e_lat);
        start = 1'b1;
        sel   = s;
        inbus = (2*W)'(x);
        @(posedge clk); #1;
        chk("busy_after_start", 64'(busy), 64'(1));
        @(negedge clk);
        start = 1'b0;
        inbus = {W'($urandom), W'(y)};
        got = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (finish === 1'b1) begin
                got = e;
                break;
            end
            @(negedge clk);
            if (inj && e == 3) begin
                start = 1'b1;
                sel   = OP_ADD;
                inbus = (2*W)'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("finish_edge", 64'(got), 64'(e_lat));
        chk("outbus", 64'(outbus), 64'(e_out));
        chk("ovf", 64'(ovf), 64'(e_ovf));
        chk("err", 64'(err), 64'(e_err));
        chk("busy_with_finish", 64'(busy), 64'(1));
        @(posedge clk); #1;
        chk("finish_fall", 64'(finish), 64'(0));
        chk("busy_fall", 64'(busy), 64'(0));
        chk("outbus_hold", 64'(outbus), 64'(e_out));
        chk("ovf_hold", 64'(ovf), 64'(e_ovf));
        chk("err_hold", 64'(err), 64'(e_err));
        @(negedge clk);
    endtask

    initial begin
        bit          seen;
        logic [1:0]  s;
        int unsigned x;
        int unsigned y;
        int unsigned hi;
        int unsigned r;

        rst   = 1'b1;
        start = 1'b0;
        sel   = 2'b00;
        inbus = '0;
        repeat (2) @(negedge clk);
        chk("rst_outbus", 64'(outbus), 64'(0));
        chk("rst_finish", 64'(finish), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_err", 64'(err), 64'(0));

        // Start presented together with reset release.
        rst = 1'b0;
        run_op(OP_ADD, 40, 12, 1'b0);
        run_op(OP_SUB, 'h7F, 'hFF, 1'b0);
        run_op(OP_SUB, 40, 12, 1'b0);
        run_op(OP_MUL, 40, 12, 1'b0);
        run_op(OP_MUL, 'h80, 'h80, 1'b0);
        run_op(OP_MUL, 'hFF, 'h03, 1'b0);
        run_op(OP_DIV, 100, 7, 1'b0);
        run_op(OP_DIV, 'h1234, 0, 1'b0);
        run_op(OP_DIV, 'h0900, 8, 1'b0);
        run_op(OP_DIV, 'hFFFF, 'hFF, 1'b0);
        run_op(OP_DIV, 'hFEFF, 'hFF, 1'b0);
        run_op(OP_MUL, 40, 12, 1'b1);
        run_op(OP_ADD, 'h80, 'h80, 1'b0);
        run_op(OP_ADD, 'h7F, 'h01, 1'b0);

        // Abort a multiply after edge 4.
        start = 1'b1;
        sel   = OP_MUL;
        inbus = 16'd40;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        inbus = 16'd12;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outbus", 64'(outbus), 64'(0));
        chk("abort_finish", 64'(finish), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_ovf", 64'(ovf), 64'(0));
        chk("abort_err", 64'(err), 64'(0));
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | finish | busy;
        end
        chk("no_activity_after_abort", 64'(seen), 64'(0));
        @(negedge clk);
        run_op(OP_ADD, 40, 12, 1'b0);

        // Random operations.
        for (int i = 0; i < 60; i++) begin
            s = 2'($urandom_range(0, 3));
            x = $urandom & 32'hFFFF;
            y = $urandom_range(1, 255);
            if (s == OP_DIV) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    y = 0;
                end else if (r == 1) begin
                    hi = $urandom_range(y, 255);
                    x  = (hi << W) | (x & 32'hFF);
                end else begin
                    hi = $urandom_range(0, y - 1);
                    x  = (hi << W) | (x & 32'hFF);
                end
            end
            run_op(s, longint'(x), longint'(y), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
